// File: rtl/pyc_sync_mem_port_ctrl_pkg.sv
// Shared sizing helpers for the sync-memory port controller and its
// response FIFO: strobe width and pointer width with a floor of 1.
package pyc_sync_mem_port_ctrl_pkg;

    function automatic int strb_w(input int dw);
        return dw / 8;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pyc_sync_mem_rsp_fifo.sv
// Response buffer: DEPTH x DATA_WIDTH FIFO that flows input straight
// to output when empty; count is registered.
module pyc_sync_mem_rsp_fifo
    import pyc_sync_mem_port_ctrl_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 64,
    localparam int PW        = ptr_w(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty, pop, buf_pop, push;

    // Explicit wrap so non-power-of-two depths work
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty     = (count_q == '0);
        out_valid = in_valid | ~empty;
        out_data  = empty ? in_data : mem_q[rd_ptr_q];
        pop       = out_valid & out_ready;
        buf_pop   = pop & ~empty;
        push      = in_valid & ~(empty & pop);
        wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = buf_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(buf_pop);
        count     = count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Credit check upstream guarantees room for every returning read
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !buf_pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/pyc_sync_mem_port_ctrl.sv
// Initiator-side controller for a 1-cycle synchronous-read memory:
// credit-gated read issue, pass-through writes, buffered read responses.
module pyc_sync_mem_port_ctrl
    import pyc_sync_mem_port_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int RSP_DEPTH   = 2,
    localparam int STRB_WIDTH = strb_w(DATA_WIDTH),
    localparam int CW         = $clog2(RSP_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wvalid,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb
);

    logic          inflight_q, inflight_d;
    logic [CW-1:0] buf_count;
    logic [CW:0]   occupancy;
    logic          rd_credit, accept;
    logic          fifo_in_valid, fifo_out_valid, fifo_out_ready;

    // A same-cycle pop never adds credit: occupancy uses registered state only
    always_comb begin
        occupancy      = {1'b0, buf_count} + {{CW{1'b0}}, inflight_q};
        rd_credit      = occupancy < (CW + 1)'(RSP_DEPTH);
        req_ready      = rst_n & (req_write | rd_credit);
        accept         = req_valid & req_ready;
        mem_ren        = accept & ~req_write;
        mem_wvalid     = accept & req_write;
        mem_raddr      = req_addr;
        mem_waddr      = req_addr;
        mem_wdata      = req_wdata;
        mem_wstrb      = req_wstrb;
        inflight_d     = mem_ren;
        fifo_in_valid  = rst_n & inflight_q;
        fifo_out_ready = rst_n & rsp_ready;
        rsp_valid      = rst_n & fifo_out_valid;
        busy           = rst_n & (inflight_q | (buf_count != '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    pyc_sync_mem_rsp_fifo #(
        .DEPTH      (RSP_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fifo_in_valid),
        .in_data   (mem_rdata),
        .out_valid (fifo_out_valid),
        .out_ready (fifo_out_ready),
        .out_data  (rsp_rdata),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_pyc_sync_mem_port_ctrl.sv
// Directed bench for pyc_sync_mem_port_ctrl with a small behavioural
// write-first byte-strobed synchronous memory attached.
module tb_pyc_sync_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_rdata;
    logic        busy;
    logic        mem_ren, mem_wvalid;
    logic [63:0] mem_raddr, mem_waddr, mem_wdata;
    logic [63:0] mem_rdata;
    logic [7:0]  mem_wstrb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pyc_sync_mem_port_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .mem_ren    (mem_ren),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_wvalid (mem_wvalid),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb)
    );

    logic [63:0] mem [16];

    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] nw,
                                          input logic [7:0]  s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_ren) begin
            if (mem_wvalid && mem_waddr[3:0] == mem_raddr[3:0])
                mem_rdata <= merge(mem[mem_raddr[3:0]], mem_wdata, mem_wstrb);
            else
                mem_rdata <= mem[mem_raddr[3:0]];
        end
        if (mem_wvalid)
            mem[mem_waddr[3:0]] <= merge(mem[mem_waddr[3:0]], mem_wdata, mem_wstrb);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [63:0] d, input logic [7:0] s);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'(a);
        req_wdata = d;
        req_wstrb = s;
    endtask

    task automatic rd(input int a);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'(a);
        req_wstrb = '0;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    function automatic logic [63:0] dv(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;

        // Reset holds everything quiet even with a request offered
        step(); rd(3);
        @(negedge clk);
        check("rst_rd_ready", req_ready, 0);
        check("rst_ren", mem_ren, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        step(); wr(3, 64'h1, 8'hFF);
        @(negedge clk);
        check("rst_wr_ready", req_ready, 0);
        check("rst_wvalid", mem_wvalid, 0);
        step(); rst_n = 1'b1; idle();

        // Full write then read
        step(); wr(5, 64'h1122334455667788, 8'hFF);
        @(negedge clk);
        check("t2_wr_ready", req_ready, 1);
        check("t2_wvalid", mem_wvalid, 1);
        step(); rd(5);
        @(negedge clk);
        check("t2_ren", mem_ren, 1);
        check("t2_busy_issue", busy, 0);
        step(); idle();
        @(negedge clk);
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rdata", rsp_rdata, 64'h1122334455667788);
        check("t2_busy", busy, 1);

        // Partial write merge
        step(); wr(5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        step(); rd(5);
        step(); idle();
        @(negedge clk);
        check("t3_rsp_valid", rsp_valid, 1);
        check("t3_rdata", rsp_rdata, 64'h11223344AAAAAAAA);

        // Back-to-back reads
        for (int i = 0; i < 8; i++) begin
            step(); wr(i, dv(i), 8'hFF);
        end
        for (int i = 0; i < 9; i++) begin
            step();
            if (i < 8) rd(i); else idle();
            @(negedge clk);
            if (i < 8) check("t4_ready", req_ready, 1);
            if (i > 0) begin
                check("t4_rsp_valid", rsp_valid, 1);
                check("t4_rdata", rsp_rdata, dv(i - 1));
            end
        end
        step(); idle();
        @(negedge clk);
        check("t4_drained_valid", rsp_valid, 0);
        check("t4_drained_busy", busy, 0);

        // Backpressure: two reads accepted, then stall
        step(); rsp_ready = 1'b0; rd(1);
        @(negedge clk);
        check("t5a_ready", req_ready, 1);
        step(); rd(2);
        @(negedge clk);
        check("t5b_ready", req_ready, 1);
        check("t5b_valid", rsp_valid, 1);
        check("t5b_rdata", rsp_rdata, dv(1));
        step(); rd(3);
        @(negedge clk);
        check("t5c_ready", req_ready, 0);
        check("t5c_ren", mem_ren, 0);
        check("t5c_rdata", rsp_rdata, dv(1));
        step();
        @(negedge clk);
        check("t5d_ready", req_ready, 0);
        check("t5d_rdata", rsp_rdata, dv(1));
        check("t5d_busy", busy, 1);
        step(); wr(9, 64'hDEADBEEFCAFEF00D, 8'hFF);
        @(negedge clk);
        check("t5e_wr_ready", req_ready, 1);
        check("t5e_wvalid", mem_wvalid, 1);
        check("t5e_rdata", rsp_rdata, dv(1));
        step(); rd(3); rsp_ready = 1'b1;
        @(negedge clk);
        check("t5f_pop_no_credit", req_ready, 0);
        check("t5f_valid", rsp_valid, 1);
        check("t5f_rdata", rsp_rdata, dv(1));
        step();
        @(negedge clk);
        check("t5g_ready", req_ready, 1);
        check("t5g_ren", mem_ren, 1);
        check("t5g_rdata", rsp_rdata, dv(2));
        step(); idle();
        @(negedge clk);
        check("t5h_valid", rsp_valid, 1);
        check("t5h_rdata", rsp_rdata, dv(3));
        step();
        @(negedge clk);
        check("t5i_valid", rsp_valid, 0);
        check("t5i_busy", busy, 0);
        step(); rd(9);
        step(); idle();
        @(negedge clk);
        check("t5j_valid", rsp_valid, 1);
        check("t5j_rdata", rsp_rdata, 64'hDEADBEEFCAFEF00D);

        // Reset with a read in flight drops it
        step(); rd(2);
        @(negedge clk);
        check("t6_issue_ready", req_ready, 1);
        step(); idle(); rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", rsp_valid, 0);
        check("t6_rst_busy", busy, 0);
        step();
        @(negedge clk);
        check("t6_rst2_valid", rsp_valid, 0);
        step(); rst_n = 1'b1;
        @(negedge clk);
        check("t6_rel_valid", rsp_valid, 0);
        check("t6_rel_busy", busy, 0);
        step(); rd(4);
        @(negedge clk);
        check("t6_rd_ready", req_ready, 1);
        check("t6_rd_valid", rsp_valid, 0);
        step(); idle();
        @(negedge clk);
        check("t6_rsp_valid", rsp_valid, 1);
        check("t6_rdata", rsp_rdata, dv(4));
        step();
        @(negedge clk);
        check("t6_end_valid", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
